// File: rtl/button_event_queue.sv
// button_event_queue: turns debounced button rises into button-index events queued in a FIFO.
// Define BTN_HOLD_EN to add one hold event per press held for HOLD_CYCLES cycles.
module button_event_queue #(
    parameter int N_BTN       = 9,
    parameter int IDW         = 4,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       pb_debounced,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [IDW-1:0]         evt_id,
    output logic                   evt_hold,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int AW = $clog2(DEPTH);
`ifdef BTN_HOLD_EN
    localparam int EW = IDW + 1;
`else
    localparam int EW = IDW;
`endif

    logic [N_BTN-1:0] prev_q, pending, rise, press_oh;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    wr_data, head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             any_press, push, pop, ovf_set, not_full;
    logic [IDW-1:0]   press_id;

    assign rise      = pb_debounced & ~prev_q;
    assign evt_valid = count != '0;
    assign evt_count = count;
    assign pop       = evt_valid & evt_ready;
    assign not_full  = count != (AW+1)'(DEPTH);
    assign head      = mem[rd_ptr];
    assign evt_id    = evt_valid ? head[IDW-1:0] : '0;

    // Descending scan so the lowest pending index is the one left selected
    always_comb begin
        any_press = 1'b0;
        press_id  = '0;
        press_oh  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any_press   = 1'b1;
                press_id    = IDW'(i);
                press_oh    = '0;
                press_oh[i] = 1'b1;
            end
        end
    end

`ifdef BTN_HOLD_EN
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    logic [HCW-1:0]   hold_cnt [N_BTN];
    logic [N_BTN-1:0] hold_pend, hold_fire, hold_oh;
    logic             any_hold;
    logic [IDW-1:0]   hold_id;

    always_comb begin
        any_hold  = 1'b0;
        hold_id   = '0;
        hold_oh   = '0;
        hold_fire = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            hold_fire[i] = pb_debounced[i] && hold_cnt[i] == HCW'(HOLD_CYCLES - 1);
            if (hold_pend[i]) begin
                any_hold   = 1'b1;
                hold_id    = IDW'(i);
                hold_oh    = '0;
                hold_oh[i] = 1'b1;
            end
        end
    end

    // Counter saturates at HOLD_CYCLES so the hold fires once per press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pend <= '0;
            for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
        end else begin
            hold_pend <= (hold_pend & ~(hold_oh & {N_BTN{push & ~any_press}})) | hold_fire;
            for (int i = 0; i < N_BTN; i++)
                hold_cnt[i] <= !pb_debounced[i] ? '0 :
                               hold_cnt[i] == HCW'(HOLD_CYCLES) ? hold_cnt[i] : hold_cnt[i] + 1'b1;
        end
    end

    assign push     = (any_press | any_hold) & not_full;
    assign wr_data  = any_press ? {1'b0, press_id} : {1'b1, hold_id};
    assign ovf_set  = (|(pending & rise)) | (|(hold_pend & hold_fire));
    assign evt_hold = evt_valid & head[IDW];
`else
    assign push     = any_press & not_full;
    assign wr_data  = press_id;
    assign ovf_set  = |(pending & rise);
    assign evt_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            pending <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            prev_q  <= pb_debounced;
            pending <= (pending & ~(press_oh & {N_BTN{push}})) | rise;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            ovf     <= ovf_set | (ovf & ~ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_button_event_queue.sv
// tb_button_event_queue: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_button_event_queue;
  localparam int N = 9, IDW = 4, DEPTH = 4, HOLD = 8, CW = 3;
  logic           clk = 1'b0, rst_n, evt_valid, evt_ready, evt_hold, ovf, ovf_clr;
  logic [N-1:0]   pb;
  logic [IDW-1:0] evt_id;
  logic [CW-1:0]  evt_count;
  int             n_checks = 0, n_fail = 0;
  button_event_queue #(.N_BTN(N), .IDW(IDW), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .pb_debounced(pb), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_hold(evt_hold), .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  int  mq[$];
  bit  m_prev[N], m_pend[N], m_hpend[N], m_ovf, m_set, m_ok;
  int  m_run[N], m_pick;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0;
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_hpend[i] = 0; m_run[i] = 0;
      end
    end else begin
      m_set = 0;
      for (int i = 0; i < N; i++) begin
        if (pb[i] && !m_prev[i] && m_pend[i]) m_set = 1;
        m_run[i] = pb[i] ? m_run[i] + 1 : 0;
`ifdef BTN_HOLD_EN
        if (m_run[i] == HOLD && m_hpend[i]) m_set = 1;
`endif
      end
      m_pick = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_pick = i;
`ifdef BTN_HOLD_EN
      if (m_pick < 0) for (int i = N - 1; i >= 0; i--) if (m_hpend[i]) m_pick = 16 + i;
`endif
      m_ok = m_pick >= 0 && mq.size() < DEPTH;
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      if (m_ok) begin
        mq.push_back(m_pick);
        if (m_pick >= 16) m_hpend[m_pick-16] = 0; else m_pend[m_pick] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (pb[i] && !m_prev[i]) m_pend[i] = 1;
`ifdef BTN_HOLD_EN
        if (m_run[i] == HOLD) m_hpend[i] = 1;
`endif
        m_prev[i] = pb[i];
      end
      m_ovf = m_set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset();
    cyc(3);
    n_checks++; if ({evt_valid, evt_count, ovf, evt_id, evt_hold} !== '0) begin n_fail++;
      $display("FAIL reset_hold: got v=%b c=%0d o=%b id=%0d h=%b required all 0", evt_valid, evt_count, ovf, evt_id, evt_hold); end
    rst_n = 1'b1;
    cyc(5);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b required 0", evt_valid); end
    n_checks++; if (evt_count !== '0) begin n_fail++; $display("FAIL idle_count: got %0d required 0", evt_count); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL idle_ovf: got %b required 0", ovf); end
  endtask
  task automatic test_single_press();
    int seen = 0;
    evt_ready = 1'b1;
    pb[3] = 1'b1;
    cyc(1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid %b required 0", evt_valid); end
    cyc(1);
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b required 1", evt_valid); end
    n_checks++; if (evt_id !== 4'd3) begin n_fail++; $display("FAIL single_id: got %0d required 3", evt_id); end
    for (int t = 0; t < 5; t++) begin
      cyc(1);
      if (evt_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL single_repeat: got %0d extra events required 0", seen); end
    pb = '0;
    cyc(3);
  endtask
  task automatic test_simultaneous();
    int exp_id[3] = '{2, 5, 7};
    evt_ready = 1'b0;
    pb = 9'b010100100;
    cyc(5);
    pb = '0;
    n_checks++; if (evt_count !== 3'd3) begin n_fail++; $display("FAIL simul_count: got %0d required 3", evt_count); end
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (evt_valid !== 1'b1 || evt_id !== IDW'(exp_id[j])) begin n_fail++;
        $display("FAIL simul_order[%0d]: got v=%b id=%0d required v=1 id=%0d", j, evt_valid, evt_id, exp_id[j]); end
      evt_ready = 1'b1;
      cyc(1);
      evt_ready = 1'b0;
    end
    n_checks++; if (evt_count !== '0) begin n_fail++; $display("FAIL simul_drain: got %0d required 0", evt_count); end
  endtask
  task automatic test_fill();
    int exp_id[6] = '{0, 1, 3, 4, 6, 8};
    int got[$];
    evt_ready = 1'b0;
    pb = 9'b101011011;
    cyc(2);
    pb = '0;
    cyc(6);
    n_checks++; if (evt_count !== 3'd4) begin n_fail++; $display("FAIL fill_full: got %0d required 4", evt_count); end
    evt_ready = 1'b1;
    for (int t = 0; t < 30 && got.size() < 6; t++) begin
      if (evt_valid) got.push_back(int'(evt_id));
      cyc(1);
    end
    evt_ready = 1'b0;
    n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL fill_total: got %0d events required 6", got.size()); end
    for (int j = 0; j < got.size() && j < 6; j++) begin
      n_checks++; if (got[j] != exp_id[j]) begin n_fail++; $display("FAIL fill_order[%0d]: got %0d required %0d", j, got[j], exp_id[j]); end
    end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf: got %b required 0", ovf); end
  endtask
  task automatic test_ovf();
    int total = 0, ones = 0;
    evt_ready = 1'b0;
    pb = 9'b000011101;
    cyc(2);
    pb = '0;
    cyc(6);
    pb[1] = 1'b1; cyc(1);
    pb[1] = 1'b0; cyc(1);
    pb[1] = 1'b1; cyc(1);
    pb[1] = 1'b0;
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", ovf); end
    n_checks++; if (evt_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d required 4", evt_count); end
    evt_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (evt_valid) begin
        total++;
        if (evt_id == 4'd1) ones++;
      end
      cyc(1);
    end
    evt_ready = 1'b0;
    n_checks++; if (total != 5) begin n_fail++; $display("FAIL ovf_total: got %0d events required 5", total); end
    n_checks++; if (ones != 1) begin n_fail++; $display("FAIL ovf_merge: got %0d events for id 1 required 1", ones); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", ovf); end
  endtask
  task automatic test_hold();
    int ev_id[$], ev_h[$], ev_t[$];
    evt_ready = 1'b1;
    pb[4] = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      cyc(1);
      if (n == 20) pb[4] = 1'b0;
      if (evt_valid) begin
        ev_id.push_back(int'(evt_id)); ev_h.push_back(int'(evt_hold)); ev_t.push_back(n);
      end
    end
`ifdef BTN_HOLD_EN
    n_checks++; if (ev_id.size() != 2) begin n_fail++; $display("FAIL hold_total: got %0d events required 2", ev_id.size()); end
    if (ev_id.size() >= 2) begin
      n_checks++; if (ev_id[1] != 4 || ev_h[1] != 1 || ev_t[1] != 9) begin n_fail++;
        $display("FAIL hold_event: got id=%0d h=%0d t=%0d required id=4 h=1 t=9", ev_id[1], ev_h[1], ev_t[1]); end
    end
`else
    n_checks++; if (ev_id.size() != 1) begin n_fail++; $display("FAIL hold_total: got %0d events required 1", ev_id.size()); end
`endif
    if (ev_id.size() >= 1) begin
      n_checks++; if (ev_id[0] != 4 || ev_h[0] != 0 || ev_t[0] != 2) begin n_fail++;
        $display("FAIL hold_press: got id=%0d h=%0d t=%0d required id=4 h=0 t=2", ev_id[0], ev_h[0], ev_t[0]); end
    end
    evt_ready = 1'b0;
    cyc(2);
  endtask
  task automatic test_async_reset();
    int total = 0, fives = 0;
    evt_ready = 1'b0;
    pb = 9'b001100000;
    cyc(4);
    n_checks++; if (evt_count !== 3'd2) begin n_fail++; $display("FAIL areset_pre: got %0d required 2", evt_count); end
    pb = 9'b000100000;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({evt_valid, evt_count, ovf, evt_id, evt_hold} !== '0) begin n_fail++;
      $display("FAIL areset_async: got v=%b c=%0d o=%b id=%0d h=%b required all 0", evt_valid, evt_count, ovf, evt_id, evt_hold); end
    cyc(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t == 3) pb = '0;
      cyc(1);
      if (evt_valid) begin
        total++;
        if (evt_id == 4'd5) fives++;
      end
    end
    n_checks++; if (total != 1 || fives != 1) begin n_fail++;
      $display("FAIL areset_held: got %0d events (%0d for id 5) required exactly 1 for id 5", total, fives); end
    evt_ready = 1'b0;
  endtask
  task automatic test_random();
    for (int c = 0; c < 1200; c++) begin
      n_checks++; if (evt_valid !== (mq.size() > 0)) begin n_fail++;
        $display("FAIL rand_valid@%0d: got %b required %0d", c, evt_valid, mq.size() > 0); end
      n_checks++; if (evt_count !== CW'(mq.size())) begin n_fail++;
        $display("FAIL rand_count@%0d: got %0d required %0d", c, evt_count, mq.size()); end
      n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf@%0d: got %b required %b", c, ovf, m_ovf); end
      if (mq.size() > 0) begin
        n_checks++; if (evt_id !== IDW'(mq[0] % 16) || evt_hold !== (mq[0] >= 16)) begin n_fail++;
          $display("FAIL rand_head@%0d: got id=%0d h=%b required id=%0d h=%0d", c, evt_id, evt_hold, mq[0] % 16, mq[0] >= 16); end
      end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) pb[i] = ~pb[i];
      evt_ready = c < 600 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ovf_clr = $urandom_range(0, 15) == 0;
      cyc(1);
    end
    pb = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
  endtask
  initial begin
    pb = '0; evt_ready = 1'b0; ovf_clr = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_fill();
    test_ovf();
    test_hold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
